// File: rtl/kws_argmax_decision_pkg.sv
// Shared types and defaults for the keyword-spotting decision stage.
// FSM encodings are fixed so other pipeline blocks can decode them.
package kws_argmax_decision_pkg;

  localparam int NUM_CLASSES_DEF    = 64;
  localparam int ACTIV_BITS_DEF     = 8;
  localparam int FILLER_CLASS_DEF   = 0;
  localparam int HOLDOFF_FRAMES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kws_argmax_decision_if.sv
// Frame-in / decision-out bundle of the argmax stage.
// master = upstream producer side, slave = decision stage.
interface kws_argmax_decision_if
  import kws_argmax_decision_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int ACTIV_BITS  = ACTIV_BITS_DEF
);

  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in;
  logic                              data_valid;
  logic [ACTIV_BITS-1:0]             threshold;
  logic                              busy;
  logic                              result_valid;
  logic [IDX_W-1:0]                  result_class;
  logic [ACTIV_BITS-1:0]             result_score;
  logic                              detect;
  logic                              frame_dropped;

  modport master (
    output data_in, data_valid, threshold,
    input  busy, result_valid, result_class,
    input  result_score, detect, frame_dropped
  );

  modport slave (
    input  data_in, data_valid, threshold,
    output busy, result_valid, result_class,
    output result_score, detect, frame_dropped
  );

endinterface

// File: rtl/kws_argmax_decision.sv
// Sequential argmax over one frame of class scores, with
// threshold detection and frame-counted detection holdoff.
module kws_argmax_decision
  import kws_argmax_decision_pkg::*;
#(
  parameter int NUM_CLASSES    = NUM_CLASSES_DEF,
  parameter int ACTIV_BITS     = ACTIV_BITS_DEF,
  parameter int FILLER_CLASS   = FILLER_CLASS_DEF,
  parameter int HOLDOFF_FRAMES = HOLDOFF_FRAMES_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  kws_argmax_decision_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam int HO_W  = cnt_w(HOLDOFF_FRAMES + 1);
  localparam int FW    = NUM_CLASSES * ACTIV_BITS;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] FILLER  = IDX_W'(FILLER_CLASS);
  localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(HOLDOFF_FRAMES);

  state_t state, state_nxt;
  logic   accept, step, decide, drop, fire;

  logic [FW-1:0]         frame_reg;
  logic [ACTIV_BITS-1:0] thr_reg;
  logic [ACTIV_BITS-1:0] best;
  logic [ACTIV_BITS-1:0] cur;
  logic [IDX_W-1:0]      best_idx;
  logic [IDX_W-1:0]      idx;
  logic [HO_W-1:0]       holdoff;
  logic [ACTIV_BITS-1:0] scores [NUM_CLASSES];

  logic                  res_valid_q;
  logic [IDX_W-1:0]      res_class_q;
  logic [ACTIV_BITS-1:0] res_score_q;
  logic                  detect_q;
  logic                  dropped_q;

  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++)
      scores[k] = frame_reg[k*ACTIV_BITS +: ACTIV_BITS];
  end

  assign cur  = scores[idx];
  assign fire = (best >= thr_reg) &&
                (best_idx != FILLER) &&
                (holdoff == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    decide    = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.data_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        step = 1'b1;
        drop = bus.data_valid;
        if (idx == LAST) state_nxt = DECIDE;
      end
      DECIDE: begin
        decide    = 1'b1;
        drop      = bus.data_valid;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_reg   <= '0;
      thr_reg     <= '0;
      best        <= '0;
      best_idx    <= '0;
      idx         <= '0;
      holdoff     <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_score_q <= '0;
      detect_q    <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      res_valid_q <= decide;
      detect_q    <= decide && fire;
      dropped_q   <= drop;
      if (accept) begin
        frame_reg <= bus.data_in;
        thr_reg   <= bus.threshold;
        best      <= bus.data_in[ACTIV_BITS-1:0];
        best_idx  <= '0;
        idx       <= IDX_W'(1);
      end
      if (step) begin
        // strict compare keeps the lowest index on ties
        if (cur > best) begin
          best     <= cur;
          best_idx <= idx;
        end
        idx <= idx + IDX_W'(1);
      end
      if (decide) begin
        res_class_q <= best_idx;
        res_score_q <= best;
        if (fire)
          holdoff <= HO_LOAD;
        else if (holdoff != '0)
          holdoff <= holdoff - HO_W'(1);
      end
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.result_valid  = res_valid_q;
  assign bus.result_class  = res_class_q;
  assign bus.result_score  = res_score_q;
  assign bus.detect        = detect_q;
  assign bus.frame_dropped = dropped_q;

endmodule
